// File: rtl/tpu_skew_feeder_pkg.sv
// tpu_pkg: definitions shared between the skew feeder and the tpumac array.
//   feed_state_t : feeder FSM state encoding
//   BITS_AB_DEF  : default operand element width (matches array Ain)
//   DIM_DEF      : default array dimension
//   pass_len()   : cycles of en_out per multiply pass (data plus drain)
package tpu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } feed_state_t;

  localparam int BITS_AB_DEF = 8;
  localparam int DIM_DEF     = 8;

  // 2*DIM-1 cycles carry data, DIM-1 zero cycles drain the last product
  // through to cell (DIM-1, DIM-1).
  function automatic int pass_len(input int dim);
    return 3 * dim - 2;
  endfunction

endpackage

// File: rtl/tpu_skew_feeder_skew_row.sv
// skew_row: one row of the operand buffer plus its skewed output register.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : parallel load of the whole row from load_data
//   load_data  : DIM elements, slice k = element k
//   stream     : next cycle is a stream step
//   step       : step index t of the next cycle
//   aout       : registered element (t - ROW), or 0 outside the row window
module skew_row
  import tpu_pkg::*;
#(
  parameter int BITS_AB = BITS_AB_DEF,
  parameter int DIM     = DIM_DEF,
  parameter int ROW     = 0,
  parameter int STEP_W  = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [DIM*BITS_AB-1:0]    load_data,
  input  logic                      stream,
  input  logic [STEP_W-1:0]         step,
  output logic signed [BITS_AB-1:0] aout
);

  logic signed [BITS_AB-1:0] elem [DIM];
  logic signed [BITS_AB-1:0] sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DIM; k++) elem[k] <= '0;
    end else if (load) begin
      for (int k = 0; k < DIM; k++) elem[k] <= $signed(load_data[k*BITS_AB +: BITS_AB]);
    end
  end

  // Row ROW lags row 0 by ROW cycles: element k appears at step k+ROW.
  always_comb begin
    sel = '0;
    for (int k = 0; k < DIM; k++) begin
      if (int'(step) == k + ROW) sel = elem[k];
    end
  end

  // Output stage: registered so no input reaches aout combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) aout <= '0;
    else        aout <= stream ? sel : '0;
  end

endmodule

// File: rtl/tpu_skew_feeder.sv
// tpu_skew_feeder: holds a DIMxDIM operand matrix A and streams it into the
// left edge of the systolic array with one cycle of skew per row, plus the
// array-wide enable for a full pass including drain cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_en      : write row wr_row of A from wr_data (IDLE only)
//   wr_row     : row index of the write
//   wr_data    : row data, slice k = A[wr_row][k]
//   start      : begin a stream pass (IDLE only, wins over wr_en)
//   busy       : high while streaming and in the done cycle
//   done       : one-cycle pulse after the last stream step
//   en_out     : enable to every array cell
//   aout       : slice i drives array row i Ain
module tpu_skew_feeder
  import tpu_pkg::*;
#(
  parameter int BITS_AB = BITS_AB_DEF,
  parameter int DIM     = DIM_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [$clog2(DIM)-1:0] wr_row,
  input  logic [DIM*BITS_AB-1:0] wr_data,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   en_out,
  output logic [DIM*BITS_AB-1:0] aout
);

  localparam int                PASS_LEN = pass_len(DIM);
  localparam int                STEP_W   = $clog2(PASS_LEN + 1);
  localparam logic [STEP_W-1:0] T_LAST   = STEP_W'(PASS_LEN - 1);

  feed_state_t       state, state_nxt;
  logic [STEP_W-1:0] t, t_nxt;
  logic              stream_nxt;
  logic              wr_ok;
  logic [DIM-1:0]    row_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      t      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      en_out <= 1'b0;
    end else begin
      state  <= state_nxt;
      t      <= t_nxt;
      busy   <= (state_nxt != IDLE);
      done   <= (state_nxt == DONE);
      en_out <= (state_nxt == STREAM);
    end
  end

  always_comb begin
    state_nxt = state;
    t_nxt     = t;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = STREAM;
          t_nxt     = '0;
        end
      end
      STREAM: begin
        if (t == T_LAST) begin
          state_nxt = DONE;
          t_nxt     = '0;
        end else begin
          t_nxt = t + STEP_W'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign stream_nxt = (state_nxt == STREAM);

  // Writes land only in IDLE; a simultaneous start takes priority, and an
  // out-of-range row (non power-of-two DIM) is dropped.
  assign wr_ok = wr_en && (state == IDLE) && !start && (int'(wr_row) < DIM);

  for (genvar i = 0; i < DIM; i++) begin : g_row
    assign row_load[i] = wr_ok && (int'(wr_row) == i);

    skew_row #(
      .BITS_AB (BITS_AB),
      .DIM     (DIM),
      .ROW     (i),
      .STEP_W  (STEP_W)
    ) u_row (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (row_load[i]),
      .load_data (wr_data),
      .stream    (stream_nxt),
      .step      (t_nxt),
      .aout      (aout[i*BITS_AB +: BITS_AB])
    );
  end

endmodule

// File: tb/tb_tpu_skew_feeder.sv
// Bench for tpu_skew_feeder at DIM=4, BITS_AB=8: a pass-cycle model checked
// every cycle, plus directed vectors with hand-computed literal values.
module tb_tpu_skew_feeder;

  localparam int BITS = 8;
  localparam int D    = 4;
  localparam int PL   = 3 * D - 2;
  localparam int NC   = PL + 3;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        wr_en   = 1'b0;
  logic [1:0]  wr_row  = '0;
  logic [31:0] wr_data = '0;
  logic        start   = 1'b0;
  logic        busy, done, en_out;
  logic [31:0] aout;

  tpu_skew_feeder #(.BITS_AB(BITS), .DIM(D)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_row  (wr_row),
    .wr_data (wr_data),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .en_out  (en_out),
    .aout    (aout)
  );

  always #5 clk = ~clk;

  // Model: matrix contents plus cycles elapsed since the accepted start
  // (-1 when idle).
  logic [7:0] am [D][D];
  int         pc = -1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++)
        for (int k = 0; k < D; k++) am[i][k] = 8'h00;
      pc = -1;
    end else if (pc < 0) begin
      if (start) pc = 0;
      else if (wr_en)
        for (int k = 0; k < D; k++) am[wr_row][k] = wr_data[k*8 +: 8];
    end else if (pc == PL) begin
      pc = -1;
    end else begin
      pc = pc + 1;
    end
  end

  // Per-cycle compare against the model.
  int          mchecks = 0;
  int          mfails  = 0;
  logic [31:0] exp_a;
  logic        exp_b, exp_d, exp_e;

  always @(negedge clk) begin
    exp_a = '0; exp_b = 1'b0; exp_d = 1'b0; exp_e = 1'b0;
    if (pc >= 0 && pc < PL) begin
      exp_b = 1'b1;
      exp_e = 1'b1;
      for (int i = 0; i < D; i++)
        if (pc - i >= 0 && pc - i < D) exp_a[i*8 +: 8] = am[i][pc - i];
    end else if (pc == PL) begin
      exp_b = 1'b1;
      exp_d = 1'b1;
    end
    mchecks++;
    if ({busy, done, en_out, aout} !== {exp_b, exp_d, exp_e, exp_a}) begin
      mfails++;
      $display("FAIL model_cycle pc=%0d got busy=%b done=%b en=%b aout=%h want busy=%b done=%b en=%b aout=%h",
               pc, busy, done, en_out, aout, exp_b, exp_d, exp_e, exp_a);
    end
  end

  // Literal checks from the stimulus process.
  int lchecks = 0;
  int lfails  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    lchecks++;
    if (act !== exp) begin
      lfails++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  logic [31:0] snap_a [NC];
  logic        snap_e [NC];
  logic        snap_d [NC];
  logic        snap_b [NC];

  task automatic load_row(input int r, input logic [31:0] d);
    wr_en = 1'b1; wr_row = 2'(r); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Issue start and record NC cycles beginning at t=0. At cycle inj, drive a
  // row-0 write of all 0xFF together with another start.
  task automatic run_pass(input int inj);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < NC; c++) begin
      snap_a[c] = aout; snap_e[c] = en_out; snap_d[c] = done; snap_b[c] = busy;
      wr_en = 1'b0; start = 1'b0;
      if (c == inj) begin
        wr_en = 1'b1; wr_row = 2'd0; wr_data = 32'hFFFF_FFFF; start = 1'b1;
      end
      @(negedge clk);
    end
    wr_en = 1'b0; start = 1'b0;
  endtask

  int n_en, n_done;

  initial begin
    for (int i = 0; i < D; i++)
      for (int k = 0; k < D; k++) am[i][k] = 8'h00;

    // Reset with random inputs.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      wr_en = 1'($urandom); start = 1'($urandom);
      wr_row = 2'($urandom); wr_data = $urandom;
    end
    @(negedge clk);
    chk("rst_aout", aout, 32'h0);
    chk("rst_ctl", {29'h0, busy, done, en_out}, 32'h0);
    wr_en = 1'b0; start = 1'b0; wr_data = '0;
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Unwritten buffer streams zeros.
    run_pass(-1);
    chk("empty_t3", snap_a[3], 32'h0);

    // A[i][k] = 16i+k+1, each start follows its last write directly.
    for (int i = 0; i < D; i++) begin
      logic [31:0] d;
      for (int k = 0; k < D; k++) d[k*8 +: 8] = 8'(16 * i + k + 1);
      load_row(i, d);
    end
    run_pass(-1);
    chk("p2_t0", snap_a[0], 32'h0000_0001);
    chk("p2_t3", snap_a[3], 32'h3122_1304);
    chk("p2_t6", snap_a[6], 32'h3400_0000);
    n_en = 0; n_done = 0;
    for (int c = 0; c < NC; c++) begin
      n_en   += int'(snap_e[c]);
      n_done += int'(snap_d[c]);
    end
    chk("p2_en_len", 32'(n_en), 32'd10);
    chk("p2_en_last", {31'h0, snap_e[9]}, 32'd1);
    chk("p2_done_c10", {31'h0, snap_d[10]}, 32'd1);
    chk("p2_done_cnt", 32'(n_done), 32'd1);
    chk("p2_busy_c11", {31'h0, snap_b[11]}, 32'd0);

    // Write and start during STREAM are ignored.
    run_pass(2);
    chk("p3_t3_row0", {24'h0, snap_a[3][7:0]}, 32'h04);
    run_pass(-1);
    chk("p3b_t0_row0", {24'h0, snap_a[0][7:0]}, 32'h01);
    chk("p3b_t3_row0", {24'h0, snap_a[3][7:0]}, 32'h04);

    // Write and start together in IDLE: start wins.
    wr_en = 1'b1; wr_row = 2'd1; wr_data = 32'h7F7F_7F7F;
    run_pass(-1);
    chk("p4_t1_row1", {24'h0, snap_a[1][15:8]}, 32'h11);
    chk("p4_t4_row1", {24'h0, snap_a[4][15:8]}, 32'h14);

    // Asynchronous reset at t=5.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("p5_async_aout", aout, 32'h0);
    chk("p5_async_ctl", {29'h0, busy, done, en_out}, 32'h0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("p5_idle_busy", {31'h0, busy}, 32'h0);
    run_pass(-1);
    chk("p5_cleared_t3", snap_a[3], 32'h0);

    // Signed extremes pass through unaltered.
    load_row(2, 32'h007F_FF80);
    run_pass(-1);
    chk("p6_t2_row2", {24'h0, snap_a[2][23:16]}, 32'h80);
    chk("p6_t3_row2", {24'h0, snap_a[3][23:16]}, 32'hFF);
    chk("p6_t4_row2", {24'h0, snap_a[4][23:16]}, 32'h7F);
    chk("p6_t5_row2", {24'h0, snap_a[5][23:16]}, 32'h00);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", mchecks + lchecks, mfails + lfails);
    $finish;
  end

endmodule
